fht_unload: RTL and testbench

- Read-out engine for the FHT core. It is the consumer of what fht_control writes on its last stage.
- Started once the core's oRDY rises. It reads the four result banks of the selected bank set in natural point order.
- Emits one sample per beat on a valid/ready stream, tagged with point index and last flag.
- Absorbs RAM read latency and downstream back-pressure with a credit-controlled output FIFO.

---
 rtl/fht_unload.sv | 227 ++++++++++++++++++++++
 tb/tb_fht_unload.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fht_unload.sv
// FHT result read-out engine: walks the four result banks of one bank set in natural
// point order and streams the samples out on a valid/ready port with index and last tags.
module fht_unload #(
    parameter int A_BIT      = 8,
    parameter int D_BIT      = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iSTART,
    input  logic               iSOURCE,
    output logic               oSOURCE,
    output logic               oRD_EN,
    output logic [A_BIT-1:0]   oADDR_RD,
    input  logic [D_BIT-1:0]   iRDATA_0,
    input  logic [D_BIT-1:0]   iRDATA_1,
    input  logic [D_BIT-1:0]   iRDATA_2,
    input  logic [D_BIT-1:0]   iRDATA_3,
    output logic [D_BIT-1:0]   oDATA,
    output logic               oVALID,
    input  logic               iREADY,
    output logic [A_BIT+1:0]   oINDEX,
    output logic               oLAST,
    output logic               oBUSY,
    output logic               oDONE
);

    localparam int K_BIT = A_BIT + 2;
    localparam logic [K_BIT-1:0] K_LAST = '1;
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IW    = $clog2(RD_LAT + 1);
    localparam int CW    = ((CNT_W > IW) ? CNT_W : IW) + 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                src_reg, src_next;
    logic [K_BIT-1:0]    rd_idx_reg, rd_idx_next;
    logic [K_BIT-1:0]    beat_cnt_reg, beat_cnt_next;
    logic                issue;
    logic                credit_ok;

    logic [RD_LAT-1:0]              stage_vld;
    logic [RD_LAT-1:0][K_BIT-1:0]   stage_k;
    logic [IW-1:0]                  inflight;

    logic                exit_vld;
    logic [K_BIT-1:0]    exit_k;
    logic [D_BIT-1:0]    exit_data;

    logic [D_BIT-1:0]    fifo_data_reg [FIFO_DEPTH];
    logic [K_BIT-1:0]    fifo_k_reg    [FIFO_DEPTH];
    logic                fifo_last_reg [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    fifo_cnt_reg, fifo_cnt_next;
    logic                push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Read pipeline: one register stage per cycle of bank RAM latency, tracking which
    // point each in-flight read belongs to.
    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
            logic               vld_in;
            logic [K_BIT-1:0]   k_in;
            logic               vld_reg;
            logic [K_BIT-1:0]   k_reg;

            if (gi == 0) begin : g_first
                assign vld_in = issue;
                assign k_in   = rd_idx_reg;
            end else begin : g_next
                assign vld_in = stage_vld[gi-1];
                assign k_in   = stage_k[gi-1];
            end

            always_ff @(posedge iCLK or negedge iRESET) begin
                if (!iRESET) begin
                    vld_reg <= 1'b0;
                    k_reg   <= '0;
                end else begin
                    vld_reg <= vld_in;
                    k_reg   <= k_in;
                end
            end

            assign stage_vld[gi] = vld_reg;
            assign stage_k[gi]   = k_reg;
        end
    endgenerate

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + IW'(stage_vld[i]);
        end
    end

    assign exit_vld = stage_vld[RD_LAT-1];
    assign exit_k   = stage_k[RD_LAT-1];

    // Point k lives in bank k[1:0], so the low index bits select the returning bank.
    always_comb begin
        exit_data = iRDATA_0;
        case (exit_k[1:0])
            2'd0:    exit_data = iRDATA_0;
            2'd1:    exit_data = iRDATA_1;
            2'd2:    exit_data = iRDATA_2;
            default: exit_data = iRDATA_3;
        endcase
    end

    // Credit check counts everything already committed to the FIFO (in flight or stored);
    // a same-cycle pop is deliberately not credited, so overflow cannot occur.
    assign credit_ok = (CW'(inflight) + CW'(fifo_cnt_reg)) < CW'(FIFO_DEPTH);

    assign oVALID = (fifo_cnt_reg != '0);
    assign push   = exit_vld;
    assign pop    = oVALID & iREADY;

    always_comb begin
        fifo_cnt_next = fifo_cnt_reg;
        case ({push, pop})
            2'b10:   fifo_cnt_next = fifo_cnt_reg + 1'b1;
            2'b01:   fifo_cnt_next = fifo_cnt_reg - 1'b1;
            default: fifo_cnt_next = fifo_cnt_reg;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_reg[i] <= '0;
                fifo_k_reg[i]    <= '0;
                fifo_last_reg[i] <= 1'b0;
            end
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (push) begin
                fifo_data_reg[wr_ptr_reg] <= exit_data;
                fifo_k_reg[wr_ptr_reg]    <= exit_k;
                fifo_last_reg[wr_ptr_reg] <= (exit_k == K_LAST);
                wr_ptr_reg                <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            fifo_cnt_reg <= fifo_cnt_next;
        end
    end

    // Output beat comes straight from the head register, so it holds while stalled.
    assign oDATA  = fifo_data_reg[rd_ptr_reg];
    assign oINDEX = fifo_k_reg[rd_ptr_reg];
    assign oLAST  = fifo_last_reg[rd_ptr_reg];

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_reg    <= S_IDLE;
            src_reg      <= 1'b0;
            rd_idx_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            src_reg      <= src_next;
            rd_idx_reg   <= rd_idx_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        src_next      = src_reg;
        rd_idx_next   = rd_idx_reg;
        beat_cnt_next = pop ? beat_cnt_reg + 1'b1 : beat_cnt_reg;
        issue         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (iSTART) begin
                    src_next      = iSOURCE;
                    rd_idx_next   = '0;
                    beat_cnt_next = '0;
                    state_next    = S_READ;
                end
            end
            S_READ: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (rd_idx_reg == K_LAST) begin
                        state_next = S_DRAIN;
                    end else begin
                        rd_idx_next = rd_idx_reg + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as soon as the final beat is taken; by then nothing else is queued.
                if (inflight == '0 && fifo_cnt_reg == CNT_W'(1) && pop &&
                    beat_cnt_reg == K_LAST) begin
                    state_next = S_DONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign oSOURCE  = src_reg;
    assign oRD_EN   = issue;
    assign oADDR_RD = issue ? rd_idx_reg[K_BIT-1:2] : '0;
    assign oBUSY    = (state_reg == S_READ) || (state_reg == S_DRAIN);
    assign oDONE    = (state_reg == S_DONE);

endmodule

// File: tb/tb_fht_unload.sv
// Bench for fht_unload: randomized back-pressure and bank contents checked against a
// point-order model; a second instance covers the minimum-latency configuration.
module tb_fht_unload;

    localparam int AB   = 3;
    localparam int DB   = 16;
    localparam int NPTS = 4 * (1 << AB);
    localparam int RL_A = 2;
    localparam int FD_A = 4;
    localparam int RL_B = 1;
    localparam int FD_B = 3;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, source = 1'b0, ready = 1'b0;
    logic ready_b = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0;
    int start_glob = 0;
    bit cur_src = 1'b0;

    logic [DB-1:0] set_a [4][NPTS/4];
    logic [DB-1:0] set_b [4][NPTS/4];

    logic            a_source, a_rd_en, a_valid, a_last, a_busy, a_done;
    logic [AB-1:0]   a_addr;
    logic [DB-1:0]   a_data;
    logic [AB+1:0]   a_index;
    logic [DB-1:0]   a_rd [4];
    logic            b_source, b_rd_en, b_valid, b_last, b_busy, b_done;
    logic [AB-1:0]   b_addr;
    logic [DB-1:0]   b_data;
    logic [AB+1:0]   b_index;
    logic [DB-1:0]   b_rd [4];

    fht_unload #(.A_BIT(AB), .D_BIT(DB), .RD_LAT(RL_A), .FIFO_DEPTH(FD_A)) u_dut (
        .iCLK(clk), .iRESET(rst_n), .iSTART(start), .iSOURCE(source),
        .oSOURCE(a_source), .oRD_EN(a_rd_en), .oADDR_RD(a_addr),
        .iRDATA_0(a_rd[0]), .iRDATA_1(a_rd[1]), .iRDATA_2(a_rd[2]), .iRDATA_3(a_rd[3]),
        .oDATA(a_data), .oVALID(a_valid), .iREADY(ready), .oINDEX(a_index),
        .oLAST(a_last), .oBUSY(a_busy), .oDONE(a_done)
    );

    fht_unload #(.A_BIT(AB), .D_BIT(DB), .RD_LAT(RL_B), .FIFO_DEPTH(FD_B)) u_dut_min (
        .iCLK(clk), .iRESET(rst_n), .iSTART(start), .iSOURCE(source),
        .oSOURCE(b_source), .oRD_EN(b_rd_en), .oADDR_RD(b_addr),
        .iRDATA_0(b_rd[0]), .iRDATA_1(b_rd[1]), .iRDATA_2(b_rd[2]), .iRDATA_3(b_rd[3]),
        .oDATA(b_data), .oVALID(b_valid), .iREADY(ready_b), .oINDEX(b_index),
        .oLAST(b_last), .oBUSY(b_busy), .oDONE(b_done)
    );

    // Bank RAM models: data appears RD_LAT cycles after the strobe, garbage otherwise.
    logic [1:0]    a_en_d = '0;
    logic [AB-1:0] a_addr_d0 = '0, a_addr_d1 = '0;
    logic          b_en_d = 1'b0;
    logic [AB-1:0] b_addr_d = '0;
    always @(posedge clk) begin
        a_en_d    <= {a_en_d[0], a_rd_en};
        a_addr_d0 <= a_addr;
        a_addr_d1 <= a_addr_d0;
        b_en_d    <= b_rd_en;
        b_addr_d  <= b_addr;
    end
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_rd[i] = a_en_d[1] ? (a_source ? set_b[i][a_addr_d1] : set_a[i][a_addr_d1]) : 16'hDEAD;
            b_rd[i] = b_en_d ? (b_source ? set_b[i][b_addr_d] : set_a[i][b_addr_d]) : 16'hBEEF;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DB-1:0] exp_word(input bit s, input int k);
        return s ? set_b[k % 4][k / 4] : set_a[k % 4][k / 4];
    endfunction

    // Minimum-latency instance always has iREADY=1: beats must be gapless from cycle 3.
    int bk = 0, b_prev = 0;
    always @(negedge clk) begin
        if (b_valid) begin
            check_eq("min index", 32'(b_index), bk);
            check_eq("min data", 32'(b_data), 32'(exp_word(cur_src, bk)));
            check_eq("min last", 32'(b_last), 32'(bk == NPTS - 1));
            if (bk == 0) check_eq("min first valid cycle", cyc - start_glob, 3);
            else         check_eq("min bubble", cyc - b_prev, 1);
            b_prev = cyc;
            bk = (bk == NPTS - 1) ? 0 : bk + 1;
        end else if (!b_busy) begin
            bk = 0;
        end
    end

    task automatic run_unload(input bit src, input int duty, input int stall_k,
                              input int restart_k, input int reset_k,
                              output int first_v, output int done_c);
        int c, issued, accepted, stall_left;
        int issue_cyc [NPTS];
        bit last_acc, done_seen, restarted, exp_valid;
        first_v = -1; done_c = -1;
        issued = 0; accepted = 0; stall_left = 10;
        last_acc = 0; done_seen = 0; restarted = 0;
        cur_src = src;
        @(negedge clk);
        c = 0; start_glob = cyc;
        start = 1'b1; source = src; ready = 1'b1;
        check_eq("idle busy", 32'(a_busy), 0);
        check_eq("idle valid", 32'(a_valid), 0);
        while (!done_seen && c < 3000) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (restart_k >= 0 && !restarted && accepted == restart_k) begin
                start = 1'b1; source = ~src; restarted = 1;
            end
            if (reset_k >= 0 && accepted == reset_k) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort flags", 32'({a_source, a_rd_en, a_valid, a_last, a_busy, a_done}), 0);
                check_eq("abort data", 32'(a_data), 0);
                check_eq("abort index", 32'(a_index), 0);
                check_eq("abort addr", 32'(a_addr), 0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("abort no done", 32'(a_done), 0);
                    check_eq("abort no valid", 32'(a_valid), 0);
                end
                return;
            end
            if (stall_k >= 0 && accepted == stall_k && stall_left > 0) begin
                ready = 1'b0; stall_left--;
            end else if (duty >= 100) begin
                ready = 1'b1;
            end else begin
                ready = ($urandom_range(99) < duty);
            end

            // A point is visible RD_LAT+1 cycles after its read strobe, in strict order.
            exp_valid = (accepted < issued) && (issue_cyc[accepted] + RL_A + 1 <= c);
            check_eq("valid", 32'(a_valid), 32'(exp_valid));
            if (a_valid) begin
                if (first_v < 0) first_v = c;
                check_eq($sformatf("index k=%0d", accepted), 32'(a_index), accepted);
                check_eq($sformatf("data k=%0d", accepted), 32'(a_data), 32'(exp_word(src, accepted)));
                check_eq("last", 32'(a_last), 32'(accepted == NPTS - 1));
            end
            check_eq("rd_en", 32'(a_rd_en), 32'(issued < NPTS && issued - accepted < FD_A));
            if (a_rd_en) check_eq("rd addr", 32'(a_addr), issued / 4);
            check_eq("done", 32'(a_done), 32'(last_acc));
            check_eq("busy", 32'(a_busy), 32'(!last_acc));
            check_eq("source", 32'(a_source), 32'(src));
            if (a_done) done_c = c;
            if (a_done || last_acc) done_seen = 1;
            last_acc = 0;
            if (a_valid && ready) begin
                accepted++;
                if (accepted == NPTS) last_acc = 1;
            end
            if (a_rd_en && issued < NPTS) begin
                issue_cyc[issued] = c;
                issued++;
            end
        end
        check_eq("completed", 32'(done_seen), 1);
        check_eq("beats", accepted, NPTS);
        @(negedge clk);
        check_eq("after busy", 32'(a_busy), 0);
        check_eq("after valid", 32'(a_valid), 0);
    endtask

    int fv, dc;
    initial begin
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < NPTS / 4; a++) begin
                set_a[b][a] = DB'(100 * b + a);
                set_b[b][a] = DB'(1000 + 4 * a + b);
            end
        repeat (3) @(negedge clk);
        check_eq("reset flags", 32'({a_source, a_rd_en, a_valid, a_last, a_busy, a_done}), 0);
        check_eq("reset data", 32'(a_data), 0);
        check_eq("reset index", 32'(a_index), 0);
        check_eq("reset min valid", 32'(b_valid), 0);
        rst_n = 1'b1;

        run_unload(1'b0, 100, -1, -1, -1, fv, dc);
        check_eq("set A first valid cycle", fv, 4);
        check_eq("set A done cycle", dc, 36);
        run_unload(1'b1, 100, -1, -1, -1, fv, dc);
        check_eq("set B first valid cycle", fv, 4);
        check_eq("set B done cycle", dc, 36);

        for (int b = 0; b < 4; b++)
            for (int a = 0; a < NPTS / 4; a++) begin
                set_a[b][a] = DB'($urandom);
                set_b[b][a] = DB'($urandom);
            end
        run_unload(1'($urandom_range(1)), 30, 5, -1, -1, fv, dc);
        run_unload(1'b0, 70, -1, 10, -1, fv, dc);
        run_unload(1'b1, 100, -1, -1, 12, fv, dc);
        run_unload(1'b1, 100, -1, -1, -1, fv, dc);
        check_eq("restart first valid cycle", fv, 4);
        check_eq("restart done cycle", dc, 36);
        run_unload(1'($urandom_range(1)), 50, -1, -1, -1, fv, dc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
